// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver slice.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    localparam int unsigned DATA_WIDTH_DEF = 8;
    localparam int unsigned MIN_PRESCALE   = 4;

    localparam logic EVEN = 1'b0;
    localparam logic ODD  = 1'b1;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle: serial line and frame configuration in, byte and status out.
interface uart_rx_if #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned PRESCALE_WIDTH = 6
);
    logic                      RX_IN;
    logic [PRESCALE_WIDTH-1:0] PRESCALE;
    logic                      PAR_EN;
    logic                      PAR_TYP;
    logic [DATA_WIDTH-1:0]     P_DATA;
    logic                      DATA_VALID;
    logic                      PAR_ERR;
    logic                      STP_ERR;

    modport master (
        output RX_IN, PRESCALE, PAR_EN, PAR_TYP,
        input  P_DATA, DATA_VALID, PAR_ERR, STP_ERR
    );

    modport slave (
        input  RX_IN, PRESCALE, PAR_EN, PAR_TYP,
        output P_DATA, DATA_VALID, PAR_ERR, STP_ERR
    );
endinterface

// File: rtl/uart_rx_sampler.sv
// Mid-bit 2-of-3 majority sampler; the first two samples are registered and the
// third is the live line, so the vote is ready in the edge_cnt = P/2+1 cycle.
module uart_rx_sampler #(
    parameter int unsigned PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      RX_IN,
    input  logic [PRESCALE_WIDTH-1:0] edge_cnt,
    input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
    output logic                      maj,
    output logic                      done
);
    logic [PRESCALE_WIDTH-1:0] half;
    logic                      s0;
    logic                      s1;

    assign half = PRESCALE >> 1;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            s0 <= 1'b1;
            s1 <= 1'b1;
        end else begin
            if (edge_cnt == half - PRESCALE_WIDTH'(1)) s0 <= RX_IN;
            if (edge_cnt == half)                      s1 <= RX_IN;
        end
    end

    // Consumers register the vote on this same edge, which keeps PRESCALE=4 working.
    assign done = (edge_cnt == half + PRESCALE_WIDTH'(1));
    assign maj  = (s0 & s1) | (s0 & RX_IN) | (s1 & RX_IN);

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start detect, majority sampling, LSB-first deserialise,
// parity/stop checks. Define UART_RX_SYNC_EN to add a 2-flop RX_IN synchroniser.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int unsigned PRESCALE_WIDTH = 6
) (
    input logic     CLK,
    input logic     RST,
    uart_rx_if.slave bus
);
    localparam int unsigned PW = PRESCALE_WIDTH;
    localparam int unsigned BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    rx_state_e             state_q, state_d;
    logic [PW-1:0]         edge_cnt, cnt_d;
    logic [BW-1:0]         bit_cnt, bit_cnt_d;
    logic [PW-1:0]         p_q, p_in, p_eff;
    logic                  par_en_q, par_typ_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic                  par_flag, stp_flag, stp_now;
    logic                  rx, maj, done, wrap;
    logic                  start_frame, frame_end;
    logic [DATA_WIDTH-1:0] p_data_q;
    logic                  valid_q, par_err_q, stp_err_q;

`ifdef UART_RX_SYNC_EN
    logic [1:0] sync_q;
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) sync_q <= '1;
        else      sync_q <= {sync_q[0], bus.RX_IN};
    end
    assign rx = sync_q[1];
`else
    assign rx = bus.RX_IN;
`endif

    assign p_in  = bus.PRESCALE & ~PW'(1);
    assign p_eff = (p_in < PW'(MIN_PRESCALE)) ? PW'(MIN_PRESCALE) : p_in;
    assign wrap  = (edge_cnt == p_q - PW'(1));

    uart_rx_sampler #(.PRESCALE_WIDTH(PW)) u_sampler (
        .CLK      (CLK),
        .RST      (RST),
        .RX_IN    (rx),
        .edge_cnt (edge_cnt),
        .PRESCALE (p_q),
        .maj      (maj),
        .done     (done)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= IDLE;
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            state_q  <= state_d;
            edge_cnt <= cnt_d;
            bit_cnt  <= bit_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = wrap ? '0 : edge_cnt + PW'(1);
        bit_cnt_d   = bit_cnt;
        start_frame = 1'b0;
        frame_end   = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d     = '0;
                bit_cnt_d = '0;
                if (!rx) begin
                    state_d     = START;
                    cnt_d       = PW'(1);
                    start_frame = 1'b1;
                end
            end
            START: begin
                if (done && maj) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (wrap) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (wrap) begin
                    if (bit_cnt == BW'(DATA_WIDTH - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt + BW'(1);
                    end
                end
            end
            PARITY: if (wrap) state_d = STOP;
            STOP: begin
                if (wrap) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    frame_end = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // With PRESCALE=4 the stop vote lands on the wrap edge, so fold it in directly.
    assign stp_now = stp_flag | ((state_q == STOP) && done && !maj);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            p_q       <= PW'(MIN_PRESCALE);
            par_en_q  <= 1'b0;
            par_typ_q <= EVEN;
            shift_q   <= '0;
            par_flag  <= 1'b0;
            stp_flag  <= 1'b0;
            p_data_q  <= '0;
            valid_q   <= 1'b0;
            par_err_q <= 1'b0;
            stp_err_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (start_frame) begin
                p_q       <= p_eff;
                par_en_q  <= bus.PAR_EN;
                par_typ_q <= bus.PAR_TYP;
                par_flag  <= 1'b0;
                stp_flag  <= 1'b0;
            end
            if (done && state_q == DATA)
                shift_q <= {maj, shift_q[DATA_WIDTH-1:1]};
            if (done && state_q == PARITY && maj != (^shift_q ^ par_typ_q))
                par_flag <= 1'b1;
            if (done && state_q == STOP && !maj)
                stp_flag <= 1'b1;
            if (frame_end) begin
                p_data_q  <= shift_q;
                par_err_q <= par_flag;
                stp_err_q <= stp_now;
                valid_q   <= !(par_flag || stp_now);
            end
        end
    end

    assign bus.P_DATA     = p_data_q;
    assign bus.DATA_VALID = valid_q;
    assign bus.PAR_ERR    = par_err_q;
    assign bus.STP_ERR    = stp_err_q;

endmodule
